// File: rtl/hevc_adder_pkg.sv
// hevc_adder_pkg: shared types and helpers for the reconstruction adder
package hevc_adder_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [1:0] SZ_4  = 2'd0;
    localparam logic [1:0] SZ_8  = 2'd1;
    localparam logic [1:0] SZ_16 = 2'd2;
    localparam logic [1:0] SZ_32 = 2'd3;

    // Samples in a square block minus one: 16 << 2*code, so 15/63/255/1023
    function automatic logic [9:0] block_samples(input logic [1:0] code);
        logic [10:0] n;
        n = 11'd16 << {code, 1'b0};
        return 10'(n - 11'd1);
    endfunction

    // Clamp a 17-bit signed sum into the 16-bit signed range
    function automatic logic [15:0] sat16(input logic signed [16:0] s);
        return (s[16] != s[15]) ? {s[16], {15{~s[16]}}} : s[15:0];
    endfunction

endpackage

// File: rtl/flux_block_ctrl.sv
// flux_block_ctrl: per-flux IDLE/RUN state and remaining-sample counter
module flux_block_ctrl
    import hevc_adder_pkg::*;
#(
    parameter int CNT_WIDTH = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [1:0] i_code,
    input  logic       i_step,
    output logic       o_in_run,
    output logic       o_last
);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;

    assign o_in_run = (r_state == RUN);
    assign o_last   = (r_cnt == '0);

    // Load the block length on a size pop, count down one per sample pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_state <= RUN;
            r_cnt   <= CNT_WIDTH'(block_samples(i_code));
        end else if (i_step) begin
            r_state <= o_last ? IDLE : RUN;
            r_cnt   <= o_last ? '0 : r_cnt - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/residual_adder.sv
// residual_adder: per-flux prediction + residual reconstruction with saturation
module residual_adder
    import hevc_adder_pkg::*;
#(
    parameter int FLUX            = 2,
    parameter int DATA_WIDTH_PRED = 8,
    parameter int DATA_WIDTH_RES  = 16,
    parameter int TAG_WIDTH       = (FLUX > 1) ? $clog2(FLUX) : 1,
    parameter int CNT_WIDTH       = 10
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [FLUX*(TAG_WIDTH+2)-1:0]             i_size_dout,
    input  logic [FLUX-1:0]                           i_size_empty,
    output logic [FLUX-1:0]                           o_size_read,
    input  logic [FLUX*(TAG_WIDTH+DATA_WIDTH_PRED)-1:0] i_pred_dout,
    input  logic [FLUX-1:0]                           i_pred_empty,
    output logic [FLUX-1:0]                           o_pred_read,
    input  logic [FLUX*(TAG_WIDTH+DATA_WIDTH_RES)-1:0] i_res_dout,
    input  logic [FLUX-1:0]                           i_res_empty,
    output logic [FLUX-1:0]                           o_res_read,
    output logic [TAG_WIDTH+DATA_WIDTH_RES-1:0]       o_sum_din,
    output logic                                      o_sum_write,
    input  logic [FLUX-1:0]                           i_sum_full
);

    localparam int SW = TAG_WIDTH + 2;
    localparam int PW = TAG_WIDTH + DATA_WIDTH_PRED;
    localparam int RW = TAG_WIDTH + DATA_WIDTH_RES;

    logic [FLUX-1:0]                w_in_run;
    logic [FLUX-1:0]                w_elig;
    logic [FLUX-1:0]                w_unused_last;
    logic [FLUX-1:0]                w_unused_tag;
    logic [FLUX-1:0]                w_onehot;
    logic [TAG_WIDTH-1:0]           w_tag;
    logic                           w_any;
    logic                           w_go;
    logic                           w_win_run;
    logic [DATA_WIDTH_PRED-1:0]     w_pred;
    logic [DATA_WIDTH_RES-1:0]      w_res;
    logic signed [DATA_WIDTH_RES:0] w_sum;

    // Fixed priority: the lowest-index eligible flux wins the cycle
    always_comb begin
        w_any = 1'b0;
        w_tag = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any = 1'b1;
                w_tag = TAG_WIDTH'(i);
            end
        end
    end

    assign w_go      = w_any & rst_n;
    assign w_win_run = w_in_run[w_tag];
    assign w_onehot  = FLUX'(1) << w_tag;
    assign w_pred    = i_pred_dout[w_tag*PW +: DATA_WIDTH_PRED];
    assign w_res     = i_res_dout[w_tag*RW +: DATA_WIDTH_RES];
    assign w_sum     = {{(DATA_WIDTH_RES + 1 - DATA_WIDTH_PRED){1'b0}}, w_pred}
                     + {w_res[DATA_WIDTH_RES-1], w_res};

    assign o_size_read = (w_go & ~w_win_run) ? w_onehot : '0;
    assign o_pred_read = (w_go &  w_win_run) ? w_onehot : '0;
    assign o_res_read  = (w_go &  w_win_run) ? w_onehot : '0;
    assign o_sum_write = w_go & w_win_run;
    assign o_sum_din   = o_sum_write ? {w_tag, sat16(w_sum)} : '0;

    genvar g;
    generate
        for (g = 0; g < FLUX; g++) begin : g_flux
            // Idle fluxes want a size token; running ones need both samples and sink room
            assign w_elig[g] = w_in_run[g]
                             ? (~i_pred_empty[g] & ~i_res_empty[g] & ~i_sum_full[g])
                             : ~i_size_empty[g];
            // Incoming tags are implied by the per-flux lane and not otherwise needed
            assign w_unused_tag[g] = ^{i_size_dout[g*SW+2 +: TAG_WIDTH],
                                       i_pred_dout[g*PW+DATA_WIDTH_PRED +: TAG_WIDTH],
                                       i_res_dout[g*RW+DATA_WIDTH_RES +: TAG_WIDTH]};
            flux_block_ctrl #(.CNT_WIDTH(CNT_WIDTH)) u_ctrl (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_load   (o_size_read[g]),
                .i_code   (i_size_dout[g*SW +: 2]),
                .i_step   (o_pred_read[g]),
                .o_in_run (w_in_run[g]),
                .o_last   (w_unused_last[g])
            );
        end
    endgenerate

endmodule
